level_column_streamer: RTL and testbench

- Sits directly upstream of the block_array column store.
- Tracks horizontal scroll from Mario's screen X and fetches 30-bit block columns (10 rows x 3-bit block id) from the level ROM.
- Presents each fetched column on new_block_id with a one-cycle Shift pulse.
- After reset, pre-fills the 10 visible columns before scrolling is enabled.

---
 rtl/level_column_streamer.sv | 165 ++++++++++++++++
 tb/tb_level_column_streamer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_column_streamer.sv
// Level column streamer: follows horizontal scroll from Mario's screen X and
// fetches 30-bit block columns from the level ROM for the block_array column store.
// Optional build macro LEVEL_WRAP_EN: wrap the level endlessly instead of freezing at its end.
`timescale 1ns/1ps

module level_column_streamer #(
  parameter logic [9:0] SCROLL_THRESH = 10'd320,
  parameter int          BLOCK_W      = 40,
  parameter int          MAX_STEP     = 4,
  parameter int          LEVEL_COLS   = 256,
  parameter int          ROM_LAT      = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [9:0]  Mario_X_Pos,
  output logic [7:0]  rom_addr,
  output logic        rom_rd,
  input  logic [29:0] rom_data,
  output logic [29:0] new_block_id,
  output logic        Shift,
  output logic [5:0]  scroll_px,
  output logic [2:0]  mario_push,
  output logic        ready,
  output logic        at_end,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    INIT_REQ   = 3'd0,
    INIT_WAIT  = 3'd1,
    INIT_LOAD  = 3'd2,
    RUN        = 3'd3,
    FETCH_REQ  = 3'd4,
    FETCH_WAIT = 3'd5,
    FETCH_LOAD = 3'd6
  } state_e;

  localparam logic [6:0] BLOCK_W7   = 7'(BLOCK_W);
  localparam logic [9:0] MAX_STEP10 = 10'(MAX_STEP);
  localparam logic [2:0] MAX_STEP3  = 3'(MAX_STEP);
  localparam logic [8:0] LAST_COL9  = 9'(LEVEL_COLS);
  localparam logic [3:0] WAIT_LAST  = 4'(ROM_LAT - 1);

  state_e      state_q;
  logic [8:0]  next_col_q;
  logic [3:0]  fill_q;
  logic [3:0]  wait_q;
  logic [7:0]  rom_addr_q;
  logic        rom_rd_q;
  logic [29:0] new_block_q;
  logic        shift_q;
  logic [5:0]  scroll_q;
  logic [2:0]  mario_push_q;
  logic        ready_q;
  logic        at_end_q;

  logic [9:0]  over_d;
  logic [2:0]  step_d;
  logic [6:0]  sum_d;
  logic [8:0]  col_inc_d;
  logic        col_end_d;
  logic        in_fetch_d;

  // Both rom_rd and Shift are single-cycle strobes with no back-pressure:
  // rom_rd qualifies rom_addr, rom_data is trusted exactly ROM_LAT cycles later,
  // and Shift qualifies new_block_id for exactly the cycle it is high.
  always_comb begin
    over_d     = Mario_X_Pos - SCROLL_THRESH;
    step_d     = 3'd0;
    if (ready_q && !at_end_q && (Mario_X_Pos > SCROLL_THRESH)) begin
      step_d = (over_d > MAX_STEP10) ? MAX_STEP3 : over_d[2:0];
    end
    sum_d      = {1'b0, scroll_q} + {4'd0, step_d};
    col_inc_d  = next_col_q + 9'd1;
    col_end_d  = (col_inc_d == LAST_COL9);
    in_fetch_d = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                 (state_q == FETCH_LOAD);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= INIT_REQ;
      next_col_q   <= 9'd0;
      fill_q       <= 4'd0;
      wait_q       <= 4'd0;
      rom_addr_q   <= 8'd0;
      rom_rd_q     <= 1'b0;
      new_block_q  <= 30'd0;
      shift_q      <= 1'b0;
      scroll_q     <= 6'd0;
      mario_push_q <= 3'd0;
      ready_q      <= 1'b0;
      at_end_q     <= 1'b0;
    end else begin
      rom_rd_q <= 1'b0;
      shift_q  <= 1'b0;
      case (state_q)
        INIT_REQ, FETCH_REQ: begin
          rom_addr_q <= next_col_q[7:0];
          rom_rd_q   <= 1'b1;
          wait_q     <= 4'd0;
          state_q    <= (state_q == INIT_REQ) ? INIT_WAIT : FETCH_WAIT;
        end
        INIT_WAIT, FETCH_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= (state_q == INIT_WAIT) ? INIT_LOAD : FETCH_LOAD;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        INIT_LOAD, FETCH_LOAD: begin
          new_block_q <= rom_data;
          shift_q     <= 1'b1;
`ifdef LEVEL_WRAP_EN
          next_col_q  <= col_end_d ? 9'd0 : col_inc_d;
`else
          next_col_q  <= col_inc_d;
          if (col_end_d) begin
            at_end_q <= 1'b1;
          end
`endif
          if (state_q == FETCH_LOAD) begin
            state_q <= RUN;
          end else begin
            fill_q <= fill_q + 4'd1;
            if (fill_q == 4'd9) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end else begin
              state_q <= INIT_REQ;
            end
          end
        end
        RUN: begin
          if (frame_tick) begin
            mario_push_q <= step_d;
            // Crossing a block boundary keeps the remainder so no pixel is lost.
            if (sum_d >= BLOCK_W7) begin
              scroll_q <= 6'(sum_d - BLOCK_W7);
              state_q  <= FETCH_REQ;
            end else begin
              scroll_q <= sum_d[5:0];
            end
          end
        end
        default: state_q <= INIT_REQ;
      endcase
      if (frame_tick && in_fetch_d) begin
        mario_push_q <= 3'd0;
      end
    end
  end

  assign rom_addr     = rom_addr_q;
  assign rom_rd       = rom_rd_q;
  assign new_block_id = new_block_q;
  assign Shift        = shift_q;
  assign scroll_px    = scroll_q;
  assign mario_push   = mario_push_q;
  assign ready        = ready_q;
  assign at_end       = at_end_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_level_column_streamer.sv
// Directed testbench for level_column_streamer with a 12-column level and a
// ROM model that returns a tag OR'd with the column index.
`timescale 1ns/1ps

module tb_level_column_streamer;

  localparam logic [29:0] TAG = 30'h2A00_0000;

  // clock / reset
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  Mario_X_Pos = 10'd0;
  logic [7:0]  rom_addr;
  logic        rom_rd;
  logic [29:0] rom_data = 30'd0;
  logic [29:0] new_block_id;
  logic        Shift;
  logic [5:0]  scroll_px;
  logic [2:0]  mario_push;
  logic        ready;
  logic        at_end;
  logic [2:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  level_column_streamer #(.LEVEL_COLS(12)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .Mario_X_Pos(Mario_X_Pos),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .new_block_id(new_block_id), .Shift(Shift), .scroll_px(scroll_px),
    .mario_push(mario_push), .ready(ready), .at_end(at_end), .dbg_state_o(dbg_state)
  );

  // ROM model: two-cycle latency, data = TAG | column index
  logic [29:0] rom_p1 = 30'd0;
  always @(posedge Clk) begin
    rom_p1   <= rom_rd ? (TAG | {22'd0, rom_addr}) : 30'd0;
    rom_data <= rom_p1;
  end

  // scoreboard logs, sampled 1ns after each rising edge
  logic [7:0]  rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [29:0] sh_data_q[$];
  int          sh_cyc_q[$];
  logic [29:0] exp_q[$];
  int cyc = 0;
  int overlap_cnt = 0;
  int dbl_cnt = 0;
  logic prev_shift = 1'b0;

  always begin
    @(posedge Clk);
    #1;
    cyc = cyc + 1;
    if (rom_rd) begin rd_addr_q.push_back(rom_addr); rd_cyc_q.push_back(cyc); end
    if (Shift) begin sh_data_q.push_back(new_block_id); sh_cyc_q.push_back(cyc); end
    if (Shift && rom_rd) overlap_cnt = overlap_cnt + 1;
    if (Shift && prev_shift) dbl_cnt = dbl_cnt + 1;
    prev_shift = Shift;
  end

  // driver tasks
  task automatic clear_logs();
    rd_addr_q.delete(); rd_cyc_q.delete(); sh_data_q.delete(); sh_cyc_q.delete(); exp_q.delete();
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick_settle();
    do_tick();
    repeat (7) @(negedge Clk);
  endtask

  // frame ticks are pulsed throughout init; they must be ignored
  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 200; i++) begin
      if (ready) break;
      frame_tick = ((i % 5) == 2);
      @(negedge Clk);
    end
    frame_tick = 1'b0;
    ok = ready;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    tests_run++; if (rom_addr !== 8'd0) begin tests_failed++; $display("FAIL reset_rom_addr: got %0h expected 0", rom_addr); end
    tests_run++; if (rom_rd !== 1'b0) begin tests_failed++; $display("FAIL reset_rom_rd: got %0b expected 0", rom_rd); end
    tests_run++; if (new_block_id !== 30'd0) begin tests_failed++; $display("FAIL reset_new_block_id: got %0h expected 0", new_block_id); end
    tests_run++; if (Shift !== 1'b0) begin tests_failed++; $display("FAIL reset_shift: got %0b expected 0", Shift); end
    tests_run++; if (scroll_px !== 6'd0) begin tests_failed++; $display("FAIL reset_scroll: got %0d expected 0", scroll_px); end
    tests_run++; if (mario_push !== 3'd0) begin tests_failed++; $display("FAIL reset_push: got %0d expected 0", mario_push); end
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %0b expected 0", ready); end
    tests_run++; if (at_end !== 1'b0) begin tests_failed++; $display("FAIL reset_at_end: got %0b expected 0", at_end); end
  endtask

  task automatic test_prefill();
    bit ok;
    int n;
    clear_logs();
    for (int k = 0; k < 10; k++) exp_q.push_back(TAG | 30'(k));
    Mario_X_Pos = 10'd400;
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_ready(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL prefill_ready_timeout: got ready=%0b expected 1", ready); end
    repeat (2) @(negedge Clk);
    tests_run++; if (sh_data_q.size() != 10) begin tests_failed++; $display("FAIL prefill_shift_count: got %0d expected 10", sh_data_q.size()); end
    tests_run++; if (rd_addr_q.size() != 10) begin tests_failed++; $display("FAIL prefill_rd_count: got %0d expected 10", rd_addr_q.size()); end
    n = (sh_data_q.size() < rd_addr_q.size()) ? sh_data_q.size() : rd_addr_q.size();
    if (n > 10) n = 10;
    for (int k = 0; k < n; k++) begin
      tests_run++; if (rd_addr_q[k] !== 8'(k)) begin tests_failed++; $display("FAIL prefill_addr[%0d]: got %0d expected %0d", k, rd_addr_q[k], k); end
      tests_run++; if (sh_data_q[k] !== exp_q[k]) begin tests_failed++; $display("FAIL prefill_data[%0d]: got %0h expected %0h", k, sh_data_q[k], exp_q[k]); end
      tests_run++; if (sh_cyc_q[k] - rd_cyc_q[k] != 3) begin tests_failed++; $display("FAIL prefill_latency[%0d]: got %0d expected 3", k, sh_cyc_q[k] - rd_cyc_q[k]); end
    end
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL prefill_ready: got %0b expected 1", ready); end
    tests_run++; if (mario_push !== 3'd0) begin tests_failed++; $display("FAIL prefill_push_ignored: got %0d expected 0", mario_push); end
    tests_run++; if (scroll_px !== 6'd0) begin tests_failed++; $display("FAIL prefill_scroll_ignored: got %0d expected 0", scroll_px); end
  endtask

  task automatic test_threshold();
    clear_logs();
    Mario_X_Pos = 10'd320;
    for (int i = 0; i < 5; i++) begin
      tick_settle();
      tests_run++; if (mario_push !== 3'd0) begin tests_failed++; $display("FAIL thresh_push[%0d]: got %0d expected 0", i, mario_push); end
      tests_run++; if (scroll_px !== 6'd0) begin tests_failed++; $display("FAIL thresh_scroll[%0d]: got %0d expected 0", i, scroll_px); end
    end
    tests_run++; if (sh_data_q.size() != 0) begin tests_failed++; $display("FAIL thresh_no_shift: got %0d expected 0", sh_data_q.size()); end
    Mario_X_Pos = 10'd322;
    do_tick();
    tests_run++; if (mario_push !== 3'd2) begin tests_failed++; $display("FAIL thresh322_push: got %0d expected 2", mario_push); end
    tests_run++; if (scroll_px !== 6'd2) begin tests_failed++; $display("FAIL thresh322_scroll: got %0d expected 2", scroll_px); end
    repeat (7) @(negedge Clk);
  endtask

  task automatic test_column_crossing();
    clear_logs();
    Mario_X_Pos = 10'd400;
    for (int i = 1; i <= 9; i++) begin
      tick_settle();
      tests_run++; if (mario_push !== 3'd4) begin tests_failed++; $display("FAIL cross_push[%0d]: got %0d expected 4", i, mario_push); end
      tests_run++; if (scroll_px !== 6'(2 + 4 * i)) begin tests_failed++; $display("FAIL cross_scroll[%0d]: got %0d expected %0d", i, scroll_px, 2 + 4 * i); end
    end
    tests_run++; if (sh_data_q.size() != 0 || rd_addr_q.size() != 0) begin tests_failed++; $display("FAIL cross_no_fetch: got shifts=%0d reads=%0d expected 0/0", sh_data_q.size(), rd_addr_q.size()); end
  endtask

  task automatic test_tick_during_fetch();
    clear_logs();
    do_tick();
    tests_run++; if (scroll_px !== 6'd2) begin tests_failed++; $display("FAIL fetch_wrap_scroll: got %0d expected 2", scroll_px); end
    tests_run++; if (mario_push !== 3'd4) begin tests_failed++; $display("FAIL fetch_wrap_push: got %0d expected 4", mario_push); end
    @(negedge Clk);
    tests_run++; if (rom_rd !== 1'b1 || rom_addr !== 8'd10) begin tests_failed++; $display("FAIL fetch_rd: got rd=%0b addr=%0d expected rd=1 addr=10", rom_rd, rom_addr); end
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    tests_run++; if (mario_push !== 3'd0) begin tests_failed++; $display("FAIL fetch_tick_push: got %0d expected 0", mario_push); end
    tests_run++; if (scroll_px !== 6'd2) begin tests_failed++; $display("FAIL fetch_tick_scroll: got %0d expected 2", scroll_px); end
    repeat (8) @(negedge Clk);
    tests_run++; if (sh_data_q.size() != 1) begin tests_failed++; $display("FAIL fetch_shift_count: got %0d expected 1", sh_data_q.size()); end
    else begin
      tests_run++; if (sh_data_q[0] !== (TAG | 30'd10)) begin tests_failed++; $display("FAIL fetch_shift_data: got %0h expected %0h", sh_data_q[0], TAG | 30'd10); end
    end
    tests_run++; if (rd_addr_q.size() != 1) begin tests_failed++; $display("FAIL fetch_rd_count: got %0d expected 1", rd_addr_q.size()); end
    do_tick();
    tests_run++; if (mario_push !== 3'd4) begin tests_failed++; $display("FAIL resume_push: got %0d expected 4", mario_push); end
    tests_run++; if (scroll_px !== 6'd6) begin tests_failed++; $display("FAIL resume_scroll: got %0d expected 6", scroll_px); end
    repeat (7) @(negedge Clk);
  endtask

  task automatic test_level_end();
    clear_logs();
    for (int i = 0; i < 8; i++) tick_settle();
    tests_run++; if (scroll_px !== 6'd38) begin tests_failed++; $display("FAIL end_pre_scroll: got %0d expected 38", scroll_px); end
    do_tick();
    tests_run++; if (scroll_px !== 6'd2) begin tests_failed++; $display("FAIL end_cross_scroll: got %0d expected 2", scroll_px); end
    repeat (7) @(negedge Clk);
    tests_run++; if (sh_data_q.size() != 1 || rd_addr_q.size() != 1) begin tests_failed++; $display("FAIL end_fetch_count: got shifts=%0d reads=%0d expected 1/1", sh_data_q.size(), rd_addr_q.size()); end
    else begin
      tests_run++; if (sh_data_q[0] !== (TAG | 30'd11)) begin tests_failed++; $display("FAIL end_shift_data: got %0h expected %0h", sh_data_q[0], TAG | 30'd11); end
      tests_run++; if (rd_addr_q[0] !== 8'd11) begin tests_failed++; $display("FAIL end_rd_addr: got %0d expected 11", rd_addr_q[0]); end
    end
`ifndef LEVEL_WRAP_EN
    tests_run++; if (at_end !== 1'b1) begin tests_failed++; $display("FAIL end_at_end: got %0b expected 1", at_end); end
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      tick_settle();
      tests_run++; if (mario_push !== 3'd0) begin tests_failed++; $display("FAIL end_push[%0d]: got %0d expected 0", i, mario_push); end
      tests_run++; if (scroll_px !== 6'd2) begin tests_failed++; $display("FAIL end_scroll[%0d]: got %0d expected 2", i, scroll_px); end
    end
    tests_run++; if (rd_addr_q.size() != 0) begin tests_failed++; $display("FAIL end_no_rd: got %0d expected 0", rd_addr_q.size()); end
    tests_run++; if (at_end !== 1'b1) begin tests_failed++; $display("FAIL end_at_end_held: got %0b expected 1", at_end); end
`else
    tests_run++; if (at_end !== 1'b0) begin tests_failed++; $display("FAIL wrap_at_end: got %0b expected 0", at_end); end
    clear_logs();
    for (int i = 0; i < 10; i++) tick_settle();
    tests_run++; if (rd_addr_q.size() != 1) begin tests_failed++; $display("FAIL wrap_rd_count: got %0d expected 1", rd_addr_q.size()); end
    else begin
      tests_run++; if (rd_addr_q[0] !== 8'd0) begin tests_failed++; $display("FAIL wrap_rd_addr: got %0d expected 0", rd_addr_q[0]); end
    end
    tests_run++; if (sh_data_q.size() != 1) begin tests_failed++; $display("FAIL wrap_shift_count: got %0d expected 1", sh_data_q.size()); end
    else begin
      tests_run++; if (sh_data_q[0] !== TAG) begin tests_failed++; $display("FAIL wrap_shift_data: got %0h expected %0h", sh_data_q[0], TAG); end
    end
    tests_run++; if (at_end !== 1'b0 || scroll_px !== 6'd2) begin tests_failed++; $display("FAIL wrap_state: got at_end=%0b scroll=%0d expected 0/2", at_end, scroll_px); end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    Mario_X_Pos = 10'd400;
    wait_ready(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmf_ready_timeout: got ready=%0b expected 1", ready); end
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 9; i++) tick_settle();
    tests_run++; if (scroll_px !== 6'd36) begin tests_failed++; $display("FAIL rmf_scroll9: got %0d expected 36", scroll_px); end
    do_tick();
    tests_run++; if (scroll_px !== 6'd0) begin tests_failed++; $display("FAIL rmf_scroll10: got %0d expected 0", scroll_px); end
    @(negedge Clk);
    tests_run++; if (rom_rd !== 1'b1 || rom_addr !== 8'd10) begin tests_failed++; $display("FAIL rmf_rd: got rd=%0b addr=%0d expected rd=1 addr=10", rom_rd, rom_addr); end
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    tests_run++; if (ready !== 1'b0 || at_end !== 1'b0) begin tests_failed++; $display("FAIL rmf_flags: got ready=%0b at_end=%0b expected 0/0", ready, at_end); end
    tests_run++; if (rom_addr !== 8'd0 || rom_rd !== 1'b0) begin tests_failed++; $display("FAIL rmf_rom: got addr=%0d rd=%0b expected 0/0", rom_addr, rom_rd); end
    tests_run++; if (Shift !== 1'b0 || new_block_id !== 30'd0) begin tests_failed++; $display("FAIL rmf_shift: got shift=%0b data=%0h expected 0/0", Shift, new_block_id); end
    tests_run++; if (scroll_px !== 6'd0 || mario_push !== 3'd0) begin tests_failed++; $display("FAIL rmf_scroll_push: got scroll=%0d push=%0d expected 0/0", scroll_px, mario_push); end
    repeat (3) @(negedge Clk);
    clear_logs();
    Reset_n = 1'b1;
    wait_ready(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rmf_refill_timeout: got ready=%0b expected 1", ready); end
    repeat (2) @(negedge Clk);
    tests_run++; if (sh_data_q.size() != 10) begin tests_failed++; $display("FAIL rmf_refill_count: got %0d expected 10", sh_data_q.size()); end
    if (sh_data_q.size() > 0 && rd_addr_q.size() > 0) begin
      tests_run++; if (rd_addr_q[0] !== 8'd0) begin tests_failed++; $display("FAIL rmf_first_addr: got %0d expected 0", rd_addr_q[0]); end
      tests_run++; if (sh_data_q[0] !== TAG) begin tests_failed++; $display("FAIL rmf_first_data: got %0h expected %0h", sh_data_q[0], TAG); end
    end else begin
      tests_run++; tests_failed++;
      $display("FAIL rmf_first: got shifts=%0d reads=%0d expected nonzero", sh_data_q.size(), rd_addr_q.size());
    end
  endtask

  task automatic test_shift_invariants();
    tests_run++; if (overlap_cnt != 0) begin tests_failed++; $display("FAIL shift_with_rd: got %0d expected 0", overlap_cnt); end
    tests_run++; if (dbl_cnt != 0) begin tests_failed++; $display("FAIL shift_back_to_back: got %0d expected 0", dbl_cnt); end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_threshold();
    test_column_crossing();
    test_tick_during_fetch();
    test_level_end();
    test_reset_mid_fetch();
    test_shift_invariants();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
